div_unit_seq: RTL and testbench
===============================

DIV_UNIT_SEQ -- requirements
Module: div_unit_seq

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width; the iteration count equals XLEN.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  request a divide; sampled only in IDLE.
REQ-005 SHALL have port: div_opcode  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start.
REQ-006 SHALL have port: operand1  input  XLEN  dividend; sampled with start.
REQ-007 SHALL have port: operand2  input  XLEN  divisor; sampled with start.
REQ-008 SHALL have port: flush  input  1  abort the in-flight operation (pipeline flush).
REQ-009 SHALL have port: busy  output  1  high when state is not IDLE.
REQ-010 SHALL have port: stall  output  1  freeze upstream pipeline stages.
REQ-011 SHALL have port: done  output  1  one-cycle pulse; result_divide valid.
REQ-012 SHALL have port: result_divide  output  XLEN  quotient or remainder for the ALU result mux.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX, DONE.
REQ-014 SHALL, in IDLE with start=1, latch opcode, |operand1|, |operand2| and sign flags (signed ops only); clear the remainder and the 6-bit counter.
REQ-015 SHALL go IDLE->CALC on start, except for the special cases in REQ-019/020, which go IDLE->DONE.
REQ-016 SHALL, in CALC, perform one restoring radix-2 step per edge: shift {rem,quot} left 1, trial-subtract divisor, set quotient LSB when the difference is non-negative; exactly XLEN steps; CALC->FIX after step XLEN.
REQ-017 SHALL, in FIX: negate the quotient when the operand signs differ (DIV); give the remainder the dividend's sign (REM); load result_divide; FIX->DONE.
REQ-018 SHALL, in DONE: assert done for exactly one cycle, then DONE->IDLE unconditionally.
REQ-019 Divide by zero: SHALL return quotient 0xFFFFFFFF (DIV/DIVU) and remainder = operand1 (REM/REMU).
REQ-020 Signed overflow (0x80000000 / 0xFFFFFFFF, DIV/REM): SHALL return quotient 0x80000000 and remainder 0.
REQ-021 Latency: SHALL assert done in the cycle after the (XLEN+1)th edge following the start-sampling edge (normal path), or the cycle after the start-sampling edge (special path).
REQ-022 SHALL drive stall = (IDLE & start) | CALC | FIX; stall SHALL be 0 in DONE so the pipeline advances and captures the result.
REQ-023 SHALL ignore start outside IDLE; SHALL accept start in the cycle after DONE.
REQ-024 SHALL hold result_divide stable from DONE until the next FIX or special-path load.
REQ-025 flush in any non-IDLE state: SHALL go to IDLE at the next edge with no done pulse; result_divide unchanged.
REQ-026 flush with start in IDLE: flush wins; the request is not accepted.

Reset
REQ-027 SHALL, on rst high, immediately force state IDLE, busy=0, stall=0, done=0, result_divide=0, counter=0, independent of clk.
REQ-028 SHALL start the first operation on the first start sampled after rst deasserts; reset mid-operation produces no done.

Verification
REQ-029 DIV 20 / -3 (0x00000014 / 0xFFFFFFFD) -> result 0xFFFFFFFA; REM with the same operands -> 0x00000002; done 33 edges after start; stall high throughout the CALC/FIX cycles.
REQ-030 DIVU 0xFFFFFFFF / 2 -> 0x7FFFFFFF; REMU with the same operands -> 0x00000001.
REQ-031 DIV 7 / 0 -> 0xFFFFFFFF and REM 7 / 0 -> 0x00000007, done one cycle after start; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-032 flush 10 cycles after start -> busy=0 next cycle, no done pulse; a following DIVU 100 / 7 -> 0x0000000E.
REQ-033 rst asserted mid-CALC -> all outputs 0 immediately; a start asserted while busy is ignored (no second done).

Source files
------------

// File: rtl/div_unit_seq.sv
// Sequential restoring radix-2 divider for DIV/DIVU/REM/REMU.
// One quotient bit per clock over XLEN cycles, then a sign-fix cycle.
// Divide-by-zero and signed overflow skip the iterations entirely.
module div_unit_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      div_opcode,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result_divide
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] divisor_q, divisor_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_quot_q, neg_quot_d;
  logic            neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] result_q, result_d;

  // Combinational helpers for the current step
  logic [XLEN:0]   diff;
  logic            signed_op;
  logic            op1_neg;
  logic            op2_neg;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      divisor_q  <= '0;
      cnt_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      divisor_q  <= divisor_d;
      cnt_q      <= cnt_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
    end
  end

  // Next-state logic, iteration step and result formation
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    op_d       = op_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    divisor_d  = divisor_q;
    cnt_d      = cnt_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    signed_op  = ~div_opcode[0];
    op1_neg    = signed_op & operand1[XLEN-1];
    op2_neg    = signed_op & operand2[XLEN-1];
    // Trial subtraction on the shifted partial remainder (one extra bit of headroom)
    diff       = {rem_q, quot_q[XLEN-1]} - {1'b0, divisor_q};

    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d       = div_opcode;
          quot_d     = op1_neg ? -operand1 : operand1;
          divisor_d  = op2_neg ? -operand2 : operand2;
          rem_d      = '0;
          cnt_d      = '0;
          neg_quot_d = op1_neg ^ op2_neg;
          neg_rem_d  = op1_neg;
          if (operand2 == '0) begin
            result_d = div_opcode[1] ? operand1 : '1;
            state_d  = S_DONE;
          end else if (signed_op && operand1 == INT_MIN && operand2 == '1) begin
            result_d = div_opcode[1] ? '0 : INT_MIN;
            state_d  = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (!diff[XLEN]) begin
            rem_d  = diff[XLEN-1:0];
            quot_d = {quot_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d  = {rem_q[XLEN-2:0], quot_q[XLEN-1]};
            quot_d = {quot_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (op_q[1]) result_d = neg_rem_q ? -rem_q : rem_q;
          else         result_d = neg_quot_q ? -quot_q : quot_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs decoded from the registered state
  assign busy          = (state_q != S_IDLE);
  assign stall         = ~rst & (((state_q == S_IDLE) & start) |
                                 (state_q == S_CALC) | (state_q == S_FIX));
  assign done          = (state_q == S_DONE);
  assign result_divide = result_q;

endmodule

// File: tb/tb_div_unit_seq.sv
// Randomized scoreboard bench for div_unit_seq: stimulus pushes expected
// results, a negedge monitor pops and compares on every done pulse.
module tb_div_unit_seq;

  localparam int XLEN = 32;
  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  div_opcode;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result_divide;

  int          checks = 0;
  int          failures = 0;
  int          done_count = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp = 32'h0;

  div_unit_seq #(.XLEN(XLEN)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .div_opcode    (div_opcode),
    .operand1      (operand1),
    .operand2      (operand2),
    .flush         (flush),
    .busy          (busy),
    .stall         (stall),
    .done          (done),
    .result_divide (result_divide)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic plus the two special cases
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == MIN_INT && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : MIN_INT;
    case (op)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 32'h0) || (!op[0] && a == MIN_INT && b == 32'hFFFF_FFFF);
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: result %0h with nothing outstanding", result_divide);
      end else begin
        check("result", result_divide, exp_q.pop_front());
      end
    end
  end

  // Full operation: issue, measure latency, watch stall/busy, let monitor compare
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit inject_start);
    int  n;
    bit  stall_ok;
    bit  special;
    logic [31:0] e;
    special = is_special(op, a, b);
    e = ref_div(op, a, b);
    @(posedge clk); #1;
    div_opcode = op; operand1 = a; operand2 = b; start = 1'b1;
    exp_q.push_back(e);
    last_exp = e;
    #1 check("stall_idle_start", stall, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    operand1 = $urandom; operand2 = $urandom; div_opcode = 2'($urandom);
    n = 0;
    stall_ok = 1'b1;
    while (done !== 1'b1 && n < 100) begin
      if (stall !== 1'b1 || busy !== 1'b1) stall_ok = 1'b0;
      if (inject_start && n == 5) begin
        start = 1'b1; operand1 = 32'd1000; operand2 = 32'd3; div_opcode = 2'b01;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check("latency", n, special ? 0 : 33);
    check("stall_busy_during_op", stall_ok, 1'b1);
    check("stall_in_done", stall, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    int dc;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    div_opcode = 2'b00; operand1 = 32'h0; operand2 = 32'h0;
    #12;
    check("reset_busy", busy, 1'b0);
    check("reset_stall", stall, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_result", result_divide, 32'h0);
    @(negedge clk); rst = 1'b0;

    // Directed cases
    run_op(2'b00, 32'd20, 32'hFFFF_FFFD, 1'b0);
    run_op(2'b10, 32'd20, 32'hFFFF_FFFD, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op(2'b11, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op(2'b00, 32'd7, 32'd0, 1'b0);
    run_op(2'b10, 32'd7, 32'd0, 1'b0);
    run_op(2'b00, MIN_INT, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b10, MIN_INT, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b01, MIN_INT, 32'hFFFF_FFFF, 1'b0);

    // Result holds stable while idle
    repeat (3) @(posedge clk);
    #1 check("result_hold", result_divide, last_exp);

    // Start while busy is ignored: exactly one done for the op
    dc = done_count;
    run_op(2'b00, 32'hFFFF_FF9C, 32'd7, 1'b1);
    repeat (40) @(posedge clk);
    #1 check("single_done_with_busy_start", done_count - dc, 1);

    // Flush ten cycles after start
    @(posedge clk); #1;
    div_opcode = 2'b01; operand1 = 32'd123456; operand2 = 32'd789; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    dc = done_count;
    @(posedge clk); #1 flush = 1'b0;
    check("flush_busy", busy, 1'b0);
    repeat (40) @(posedge clk);
    #1 check("flush_no_done", done_count - dc, 0);
    check("flush_result_kept", result_divide, last_exp);
    run_op(2'b01, 32'd100, 32'd7, 1'b0);

    // Reset mid-CALC: outputs drop immediately, no done afterwards
    @(posedge clk); #1;
    div_opcode = 2'b00; operand1 = 32'd5000; operand2 = 32'd9; start = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result_divide, 32'h0);
    start = 1'b0;
    dc = done_count;
    @(negedge clk); rst = 1'b0;
    repeat (40) @(posedge clk);
    #1 check("rst_no_done", done_count - dc, 0);
    last_exp = 32'h0;

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'h0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        3:       begin a = MIN_INT; b = 32'hFFFF_FFFF; end
        4:       b = 32'($urandom_range(1, 1000)) * 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      run_op(op, a, b, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1 check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
